if_fetch_unit: RTL and testbench

- Instruction-fetch stage of the pipelined CPU. It sits directly upstream of the PC pipeline register and the IF/ID register.
- Generates fetch addresses to a synchronous instruction ROM with 1-cycle read latency. Pairs each returned word with its PC and presents the pair downstream.
- Holds the pair across downstream stalls through a 1-entry hold buffer, and redirects on taken branches and jumps.

---
 rtl/if_fetch_unit.sv | 99 +++++++++
 tb/tb_if_fetch_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage. It issues sequential word fetches to a synchronous
// instruction ROM that has one cycle of read latency. Each returned word is
// paired with its PC and presented downstream. A one-entry hold buffer keeps
// that pair steady while the downstream stage stalls. A taken branch or jump
// from EX redirects the fetch address.
//
// Ports:
//   clk            system clock, rising edge
//   rstn           asynchronous active-low reset
//   stall          downstream hold; the presented instruction is not consumed
//   redirect_valid taken branch/jump from EX; takes priority over stall
//   redirect_pc    redirect target; low two bits are dropped and flagged
//   irom_en        ROM read request this cycle
//   irom_addr      ROM read address (word aligned)
//   irom_rdata     ROM data, valid the cycle after a request
//   pc_out         PC of the presented instruction (0 when not valid)
//   inst_out       presented instruction (NOP_INST when not valid)
//   inst_valid     pc_out/inst_out carry a live instruction
//   misalign       one-cycle registered pulse: last redirect target was misaligned
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned PC_STEP  = 4,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        irom_en,
   output logic [31:0] irom_addr,
   input  logic [31:0] irom_rdata,
   output logic [31:0] pc_out,
   output logic [31:0] inst_out,
   output logic        inst_valid,
   output logic        misalign
);

   localparam int unsigned XLEN = 32;

   logic [XLEN-1:0] pc_f;
   logic            resp_valid;
   logic [XLEN-1:0] resp_pc;
   logic            hold_valid;
   logic [XLEN-1:0] hold_pc;
   logic [XLEN-1:0] hold_inst;
   logic            src_valid;
   logic [XLEN-1:0] src_pc;
   logic [XLEN-1:0] src_inst;

   // A request is issued only when the stage advances. It is gated by rstn so
   // that nothing is issued while reset is asserted.
   assign irom_en   = rstn & ~stall & ~redirect_valid;
   assign irom_addr = pc_f;

   // The hold entry has priority over the in-flight response.
   assign src_valid = hold_valid | resp_valid;
   assign src_pc    = hold_valid ? hold_pc   : resp_pc;
   assign src_inst  = hold_valid ? hold_inst : irom_rdata;

   assign inst_valid = rstn & src_valid & ~redirect_valid;
   assign pc_out     = inst_valid ? src_pc   : '0;
   assign inst_out   = inst_valid ? src_inst : NOP_INST;

   // Fetch pointer, in-flight tracking, hold buffer and misalign flag.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pc_f       <= RESET_PC;
         resp_valid <= 1'b0;
         resp_pc    <= '0;
         hold_valid <= 1'b0;
         hold_pc    <= '0;
         hold_inst  <= '0;
         misalign   <= 1'b0;
      end else begin
         misalign <= redirect_valid && (redirect_pc[1:0] != 2'b00);
         if (redirect_valid) begin
            pc_f       <= {redirect_pc[XLEN-1:2], 2'b00};
            resp_valid <= 1'b0;
            hold_valid <= 1'b0;
         end else if (stall) begin
            resp_valid <= 1'b0;
            // Catch the returning word; the ROM output is gone next cycle.
            if (resp_valid && !hold_valid) begin
               hold_valid <= 1'b1;
               hold_pc    <= resp_pc;
               hold_inst  <= irom_rdata;
            end
         end else begin
            // Presented word is consumed and the next fetch issues together.
            pc_f       <= pc_f + XLEN'(PC_STEP);
            resp_pc    <= pc_f;
            resp_valid <= 1'b1;
            hold_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Testbench for if_fetch_unit. Two instances run side by side. The main one
// uses RESET_PC=0 and receives directed and random stall/redirect traffic. The
// second uses RESET_PC=FFFF_FFF8 and free-runs to exercise address wrap. The
// reference model treats fetched PCs as a queue: each issued fetch becomes
// presentable next cycle, consumption pops the queue, and a redirect flushes it.
module tb_if_fetch_unit;

   localparam logic [31:0] NOP    = 32'h0000_0013;
   localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;
   localparam logic [31:0] JUNK   = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   logic        rstn;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   logic        irom_en, inst_valid, misalign;
   logic [31:0] irom_addr, irom_rdata, pc_out, inst_out;

   logic        w_irom_en, w_inst_valid, w_misalign;
   logic [31:0] w_irom_addr, w_irom_rdata, w_pc_out, w_inst_out;

   int unsigned compared   = 0;
   int unsigned mismatched = 0;

   logic [31:0] m_next;
   logic [31:0] m_q[$];
   logic        m_mis;
   logic [31:0] w_next;
   logic [31:0] w_q[$];

   always #5 clk = ~clk;

   if_fetch_unit dut (
      .clk(clk), .rstn(rstn), .stall(stall), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .irom_en(irom_en), .irom_addr(irom_addr),
      .irom_rdata(irom_rdata), .pc_out(pc_out), .inst_out(inst_out),
      .inst_valid(inst_valid), .misalign(misalign)
   );

   if_fetch_unit #(.RESET_PC(WRAP_PC)) dut_w (
      .clk(clk), .rstn(rstn), .stall(1'b0), .redirect_valid(1'b0),
      .redirect_pc(32'h0), .irom_en(w_irom_en), .irom_addr(w_irom_addr),
      .irom_rdata(w_irom_rdata), .pc_out(w_pc_out), .inst_out(w_inst_out),
      .inst_valid(w_inst_valid), .misalign(w_misalign)
   );

   // ROM contents: a distinct word per address.
   function automatic logic [31:0] rom(input logic [31:0] a);
      return {a[31:2], 2'b00} ^ 32'hC0DE_0001;
   endfunction

   // Synchronous ROMs; data outside a response cycle is junk.
   always_ff @(posedge clk) begin
      irom_rdata   <= irom_en   ? rom(irom_addr)   : JUNK;
      w_irom_rdata <= w_irom_en ? rom(w_irom_addr) : JUNK;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_next = 32'h0;
      m_q.delete();
      m_mis  = 1'b0;
      w_next = WRAP_PC;
      w_q.delete();
   endtask

   // Called at a negedge: drive, check, cross the posedge, update the model,
   // then return at the next negedge.
   task automatic step(input logic s, input logic r, input logic [31:0] t);
      logic        ev;
      logic [31:0] epc;
      stall          = s;
      redirect_valid = r;
      redirect_pc    = t;
      #1;
      ev  = (m_q.size() != 0) && !r;
      epc = ev ? m_q[0] : 32'h0;
      chk("irom_en",    32'(irom_en),    32'(!s && !r));
      chk("irom_addr",  irom_addr,       m_next);
      chk("inst_valid", 32'(inst_valid), 32'(ev));
      chk("pc_out",     pc_out,          epc);
      chk("inst_out",   inst_out,        ev ? rom(epc) : NOP);
      chk("misalign",   32'(misalign),   32'(m_mis));
      chk("w_irom_addr",  w_irom_addr,       w_next);
      chk("w_inst_valid", 32'(w_inst_valid), 32'(w_q.size() != 0));
      chk("w_pc_out",     w_pc_out,          (w_q.size() != 0) ? w_q[0] : 32'h0);
      @(posedge clk);
      m_mis = r && (t[1:0] != 2'b00);
      if (r) begin
         m_q.delete();
         m_next = {t[31:2], 2'b00};
      end else if (!s) begin
         if (m_q.size() != 0) void'(m_q.pop_front());
         m_q.push_back(m_next);
         m_next = m_next + 32'd4;
      end
      if (w_q.size() != 0) void'(w_q.pop_front());
      w_q.push_back(w_next);
      w_next = w_next + 32'd4;
      @(negedge clk);
   endtask

   initial begin
      rstn           = 1'b0;
      stall          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      chk("rst_irom_en",    32'(irom_en),    32'h0);
      chk("rst_inst_valid", 32'(inst_valid), 32'h0);
      chk("rst_pc_out",     pc_out,          32'h0);
      chk("rst_inst_out",   inst_out,        NOP);
      chk("rst_misalign",   32'(misalign),   32'h0);
      chk("rst_w_addr",     w_irom_addr,     WRAP_PC);
      @(negedge clk);
      rstn = 1'b1;

      // Sequential start-up, then a stall while 0x8 is presented.
      step(0, 0, 0);
      step(0, 0, 0);
      step(0, 0, 0);
      step(1, 0, 0);
      step(1, 0, 0);
      step(1, 0, 0);
      step(0, 0, 0);
      step(0, 0, 0);
      // Redirect to 0x100 while stalled with a full hold entry.
      step(1, 0, 0);
      step(1, 1, 32'h0000_0100);
      step(0, 0, 0);
      step(0, 0, 0);
      // Misaligned redirect.
      step(0, 1, 32'h0000_0103);
      step(0, 0, 0);
      step(0, 0, 0);
      step(0, 0, 0);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 9) < 3) ? 1'b1 : 1'b0,
              ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0,
              $urandom);
      end

      // Asynchronous reset mid-stall with a full hold entry.
      step(0, 0, 0);
      step(0, 0, 0);
      step(1, 0, 0);
      step(1, 0, 0);
      #2;
      rstn           = 1'b0;
      stall          = 1'b0;
      redirect_valid = 1'b0;
      #1;
      chk("arst_irom_en",    32'(irom_en),    32'h0);
      chk("arst_inst_valid", 32'(inst_valid), 32'h0);
      chk("arst_pc_out",     pc_out,          32'h0);
      chk("arst_inst_out",   inst_out,        NOP);
      chk("arst_w_irom_en",  32'(w_irom_en),  32'h0);
      model_reset();
      @(negedge clk);
      rstn = 1'b1;
      for (int i = 0; i < 6; i++) step(0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
